// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one acia_tx between N byte producers.
// Define UART_TX_SCHED_HEADER_EN to prefix each payload byte with a 8'h80|id source header.
module uart_tx_sched #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_dat,
  output logic [N-1:0]   ack,
  input  logic           tx_busy,
  output logic [7:0]     tx_dat,
  output logic           tx_start,
  output logic           frame_active,
  output logic [IW-1:0]  grant_id
);

  typedef enum logic [2:0] {IDLE, HDR_START, HDR_WAIT, DAT_START, DAT_WAIT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_id_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    tx_dat_d;
  logic          tx_start_d;
  logic          frame_active_d;
  logic [N-1:0]  ack_d;
  logic          wait_first_q, wait_first_d;

  logic          found;
  logic [IW-1:0] winner;
  int            idx;

  // Search upward from last+1 so the most recent winner gets lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    grant_id_d     = grant_id;
    dat_d          = dat_q;
    tx_dat_d       = tx_dat;
    tx_start_d     = 1'b0;
    frame_active_d = frame_active;
    ack_d          = '0;
    wait_first_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          ack_d          = N'(1) << winner;
          last_d         = winner;
          grant_id_d     = winner;
          dat_d          = req_dat[8*winner +: 8];
          frame_active_d = 1'b1;
`ifdef UART_TX_SCHED_HEADER_EN
          state_d        = HDR_START;
`else
          state_d        = DAT_START;
`endif
        end
      end
`ifdef UART_TX_SCHED_HEADER_EN
      HDR_START: begin
        tx_dat_d     = 8'h80 | 8'(grant_id);
        tx_start_d   = 1'b1;
        wait_first_d = 1'b1;
        state_d      = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (!wait_first_q && !tx_busy) state_d = DAT_START;
      end
`endif
      DAT_START: begin
        tx_dat_d     = dat_q;
        tx_start_d   = 1'b1;
        wait_first_d = 1'b1;
        state_d      = DAT_WAIT;
      end
      // acia_tx raises busy one cycle after it samples start, so the first wait cycle is blind.
      DAT_WAIT: begin
        if (!wait_first_q && !tx_busy) begin
          state_d        = IDLE;
          frame_active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= IW'(N-1);
      grant_id     <= '0;
      dat_q        <= '0;
      tx_dat       <= '0;
      tx_start     <= 1'b0;
      frame_active <= 1'b0;
      ack          <= '0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_id     <= grant_id_d;
      dat_q        <= dat_d;
      tx_dat       <= tx_dat_d;
      tx_start     <= tx_start_d;
      frame_active <= frame_active_d;
      ack          <= ack_d;
      wait_first_q <= wait_first_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-level timing model plus directed scenarios with literal expectations.
module tb_uart_tx_sched;
  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int BUSY_LEN = 10;
`ifdef UART_TX_SCHED_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_dat = '0;
  logic [N-1:0]   ack;
  logic           tx_busy;
  logic [7:0]     tx_dat;
  logic           tx_start;
  logic           frame_active;
  logic [IW-1:0]  grant_id;

  logic           force_busy = 1'b0;
  logic [N-1:0]   keep = '0;
  int             busy_cnt;
  int             cyc = 0;
  int             checks = 0;
  int             failures = 0;

  uart_tx_sched #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dat(req_dat), .ack(ack),
    .tx_busy(tx_busy), .tx_dat(tx_dat), .tx_start(tx_start),
    .frame_active(frame_active), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // acia_tx stand-in: busy from the cycle after start for BUSY_LEN cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: grant rule, byte sequence and timing relative to tx_busy edges.
  int         mlast = N-1;
  bit         fa_exp = 0, ack_pend = 0, prev_busy = 0, inflight = 0, mfound;
  int         exp_id = 0, start_due = -1, drop_due = -1, mj;
  logic [7:0] exp_byte;
  logic [7:0] exp_q[$];
  int         gnt_log[$];
  logic [7:0] tx_log[$];
  int         start_log[$];
  int         frames_done = 0, last_ack_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      mlast = N-1; fa_exp = 0; ack_pend = 0; prev_busy = 0; inflight = 0;
      start_due = -1; drop_due = -1; exp_q.delete();
    end else begin
      if (ack_pend) begin
        chk("ack_grant", 32'(ack), 32'(1) << exp_id);
        chk("grant_id", 32'(grant_id), exp_id);
        ack_pend = 0; fa_exp = 1; start_due = cyc + 1;
        gnt_log.push_back(exp_id); last_ack_cyc = cyc;
        if (HDR) exp_q.push_back(8'h80 | 8'(exp_id));
        exp_q.push_back(exp_byte);
      end else begin
        chk("ack_quiet", 32'(ack), 0);
      end
      if (cyc == drop_due) begin
        fa_exp = 0; drop_due = -1; frames_done++;
      end
      chk("frame_active", 32'(frame_active), 32'(fa_exp));
      if (prev_busy && !tx_busy && inflight) begin
        inflight = 0;
        if (exp_q.size() > 0) start_due = cyc + 2;
        else drop_due = cyc + 1;
      end
      chk("tx_start", 32'(tx_start), 32'(cyc == start_due));
      if (tx_start) begin
        tx_log.push_back(tx_dat); start_log.push_back(cyc); inflight = 1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_dat: unexpected byte %0h (cycle %0d)", tx_dat, cyc);
        end else begin
          exp_byte = exp_q.pop_front();
          if (tx_dat !== exp_byte) begin
            failures++;
            $display("FAIL tx_dat: got %0h expected %0h (cycle %0d)", tx_dat, exp_byte, cyc);
          end
        end
      end
      if (start_due >= 0 && cyc >= start_due) start_due = -1;
      if (!fa_exp && req != 0 && !tx_busy) begin
        mfound = 0;
        for (int k = 1; k <= N; k++) begin
          mj = (mlast + k) % N;
          if (!mfound && req[mj]) begin mfound = 1; exp_id = mj; end
        end
        mlast = exp_id; ack_pend = 1; exp_byte = req_dat[8*exp_id +: 8];
      end
      prev_busy = tx_busy;
    end
  end

  // Requesters drop req on ack unless marked keep, in which case they load a new byte.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (!rst && ack[i]) begin
        if (keep[i]) req_dat[8*i +: 8] = req_dat[8*i +: 8] + 8'h11;
        else req[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int base = frames_done;
    int t = 0;
    while ((frames_done - base) < n && t < budget) begin step(); t++; end
    checks++;
    if ((frames_done - base) < n) begin
      failures++;
      $display("FAIL %s timeout: frames %0d expected %0d", name, frames_done - base, n);
    end
  endtask

  task automatic drain();
    int t = 0;
    req = '0; keep = '0;
    step();
    while (frame_active && t < 200) begin step(); t++; end
    checks++;
    if (frame_active) begin
      failures++;
      $display("FAIL drain timeout: frame_active %0d expected 0", frame_active);
    end
    repeat (3) step();
  endtask

  task automatic clear_logs();
    gnt_log.delete(); tx_log.delete(); start_log.delete();
  endtask

  function automatic int gnt_at(input int k);
    return (gnt_log.size() > k) ? gnt_log[k] : -1;
  endfunction

  function automatic logic [31:0] tx_at(input int k);
    return (tx_log.size() > k) ? 32'(tx_log[k]) : 32'hFFFF_FFFF;
  endfunction

  logic [7:0] exp_bytes[$];
  int         c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_dat", 32'(tx_dat), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_frame_active", 32'(frame_active), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    rst = 1'b0;
    step();

    // Contention: all four request at once, each drops on its ack.
    clear_logs();
    req_dat = 32'hD3D2D1D0; req = 4'b1111;
    wait_frames(4, 400, "contention");
    drain();
    for (int i = 0; i < 4; i++) chk("cont_order", gnt_at(i), i);
    chk("cont_grants", gnt_log.size(), 4);
    exp_bytes.delete();
    for (int i = 0; i < 4; i++) begin
      if (HDR) exp_bytes.push_back(8'h80 + 8'(i));
      exp_bytes.push_back(8'hD0 + 8'(i));
    end
    chk("cont_nbytes", tx_log.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) chk("cont_byte", tx_at(i), 32'(exp_bytes[i]));

    // Fairness: requesters 1 and 3 both re-request immediately after every ack.
    clear_logs();
    req_dat = 32'h30001000; keep = 4'b1010; req = 4'b1010;
    wait_frames(4, 400, "fairness");
    drain();
    chk("fair_0", gnt_at(0), 1);
    chk("fair_1", gnt_at(1), 3);
    chk("fair_2", gnt_at(2), 1);
    chk("fair_3", gnt_at(3), 3);

    // Single request on 2.
    clear_logs();
    req_dat[23:16] = 8'h5A; req = 4'b0100;
    wait_frames(1, 200, "single");
    chk("single_frame_active", 32'(frame_active), 0);
    drain();
    chk("single_gnt", gnt_at(0), 2);
    chk("single_grants", gnt_log.size(), 1);
    exp_bytes.delete();
    if (HDR) exp_bytes.push_back(8'h82);
    exp_bytes.push_back(8'h5A);
    chk("single_nbytes", tx_log.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) chk("single_byte", tx_at(i), 32'(exp_bytes[i]));
    chk("single_start_lat", (start_log.size() > 0) ? start_log[0] - last_ack_cyc : -1, 1);

    // Busy guard: nothing may be granted while the transmitter reports busy.
    clear_logs();
    force_busy = 1'b1; req_dat[7:0] = 8'h3C; req = 4'b0001;
    repeat (20) step();
    chk("guard_no_grant", gnt_log.size(), 0);
    chk("guard_no_start", tx_log.size(), 0);
    force_busy = 1'b0; c0 = cyc;
    wait_frames(1, 200, "busy_guard");
    drain();
    chk("guard_gnt", gnt_at(0), 0);
    chk("guard_ack_cycle", last_ack_cyc - c0, 1);

    // Reset during the final byte's wait, then 1 and 3 request together.
    clear_logs();
    req_dat[15:8] = 8'h77; req = 4'b0010;
    begin
      int t = 0;
      while (tx_log.size() < (HDR ? 2 : 1) && t < 200) begin step(); t++; end
    end
    chk("rmf_bytes_sent", tx_log.size(), HDR ? 2 : 1);
    repeat (3) step();
    chk("rmf_active_before", 32'(frame_active), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rmf_ack", 32'(ack), 0);
    chk("rmf_tx_dat", 32'(tx_dat), 0);
    chk("rmf_tx_start", 32'(tx_start), 0);
    chk("rmf_frame_active", 32'(frame_active), 0);
    chk("rmf_grant_id", 32'(grant_id), 0);
    repeat (2) step();
    rst = 1'b0;
    clear_logs();
    req_dat = 32'h44003300; req = 4'b1010;
    wait_frames(1, 200, "reset_regrant");
    drain();
    chk("rmf_first_gnt", gnt_at(0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
